// File: rtl/cd74hc4516.sv
// CD74HC4516 presettable 4-bit binary up/down counter with active-low carry in/out.
// Datasheet pin numbering: q = {pin2,pin14,pin11,pin6}, p = {pin3,pin13,pin12,pin4}.
module cd74hc4516 (
  input  logic pin15,  // CLOCK
  input  logic pin9,   // RESET (MR), async active-high
  input  logic pin1,   // PRESET ENABLE
  input  logic pin10,  // UP/DOWN
  input  logic pin5,   // CARRY IN, active-low
  input  logic pin4,   // P1
  input  logic pin12,  // P2
  input  logic pin13,  // P3
  input  logic pin3,   // P4
  output logic pin6,   // Q1
  output logic pin11,  // Q2
  output logic pin14,  // Q3
  output logic pin2,   // Q4
  output logic pin7,   // CARRY OUT, active-low
  output logic pin8,   // VSS
  output logic pin16   // VDD
);

  localparam int unsigned W = 4;

  logic [W-1:0] q;
  logic [W-1:0] p;
  logic [W-1:0] q_nxt;
  logic         cnt_en;
  logic         term;

  assign p      = {pin3, pin13, pin12, pin4};
  assign cnt_en = ~pin5;

  // Next count value: modulo-16 step in the selected direction, or hold.
  always_comb begin
    q_nxt = q;
    if (cnt_en) begin
      if (pin10) q_nxt = q + W'(1);
      else       q_nxt = q - W'(1);
    end
  end

  // Reset and the PE rising edge act without a clock; PE held high reloads on each clock.
  always_ff @(posedge pin15 or posedge pin9 or posedge pin1) begin
    if (pin9)      q <= '0;
    else if (pin1) q <= p;
    else           q <= q_nxt;
  end

  // Terminal count in the current direction, gated by carry in.
  assign term = pin10 ? (q == {W{1'b1}}) : (q == {W{1'b0}});
  assign pin7 = ~(cnt_en & term);

  assign {pin2, pin14, pin11, pin6} = q;
  assign pin8  = 1'b0;
  assign pin16 = 1'b1;

endmodule

// File: tb/tb_cd74hc4516.sv
// Bench for cd74hc4516: vector table, hand-written corner sequences, cascade,
// and randomized stimulus against an arithmetic reference model.
module tb_cd74hc4516;

  logic       clk, rst, pe, up, ci_n;
  logic [3:0] p;
  logic       q1, q2, q3, q4, co_n, vss, vdd;
  logic       h1, h2, h3, h4, hco_n, hvss, hvdd;
  logic       pe_hi;
  logic [3:0] p_hi;

  int n_chk  = 0;
  int n_pass = 0;

  cd74hc4516 u_lo (
    .pin15(clk), .pin9(rst), .pin1(pe), .pin10(up), .pin5(ci_n),
    .pin4(p[0]), .pin12(p[1]), .pin13(p[2]), .pin3(p[3]),
    .pin6(q1), .pin11(q2), .pin14(q3), .pin2(q4),
    .pin7(co_n), .pin8(vss), .pin16(vdd)
  );

  cd74hc4516 u_hi (
    .pin15(clk), .pin9(rst), .pin1(pe_hi), .pin10(up), .pin5(co_n),
    .pin4(p_hi[0]), .pin12(p_hi[1]), .pin13(p_hi[2]), .pin3(p_hi[3]),
    .pin6(h1), .pin11(h2), .pin14(h3), .pin2(h4),
    .pin7(hco_n), .pin8(hvss), .pin16(hvdd)
  );

  typedef struct {
    logic rst, pe, up, ci_n;
    int   p;
    int   exp_q;
    int   exp_co;
  } vec_t;

  function automatic int qv();
    return int'({q4, q3, q2, q1});
  endfunction

  function automatic int hv();
    return int'({h4, h3, h2, h1});
  endfunction

  function automatic int co_model(int q, logic u, logic c);
    if (c == 1'b0 && ((u && q == 15) || (!u && q == 0))) return 0;
    return 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    clk = 1'b1; #5;
    clk = 1'b0; #5;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; #2;
    rst = 1'b0; #2;
  endtask

  task automatic async_load(input int val);
    pe = 1'b0; #1;
    p = 4'(val);
    pe = 1'b1; #1;
    pe = 1'b0; #1;
  endtask

  vec_t vt[$];

  initial begin
    int mq;
    logic prev_pe;

    clk = 0; rst = 0; pe = 0; up = 1; ci_n = 0; p = '0;
    pe_hi = 0; p_hi = '0;

    // Reset state and supply pins
    rst = 1'b1; #1;
    chk("reset_q", qv(), 0);
    chk("reset_co_up", int'(co_n), 1);
    up = 1'b0; #1;
    chk("reset_co_down", int'(co_n), 0);
    chk("vss", int'(vss), 0);
    chk("vdd", int'(vdd), 1);
    rst = 1'b0; up = 1'b1; #4;

    // Vector table: inputs applied with clk low, then one clock, then checked
    //              rst  pe   up   ci_n p   q   co
    vt.push_back('{1'b1,1'b0,1'b1,1'b0, 0,  0, 1});
    vt.push_back('{1'b0,1'b0,1'b1,1'b0, 0,  1, 1});
    vt.push_back('{1'b0,1'b0,1'b1,1'b0, 0,  2, 1});
    vt.push_back('{1'b0,1'b1,1'b1,1'b0,14, 14, 1});
    vt.push_back('{1'b0,1'b0,1'b1,1'b0, 9, 15, 0});
    vt.push_back('{1'b0,1'b0,1'b1,1'b0, 9,  0, 1});
    vt.push_back('{1'b0,1'b0,1'b0,1'b0, 9, 15, 1});
    vt.push_back('{1'b0,1'b0,1'b0,1'b1, 9, 15, 1});
    vt.push_back('{1'b0,1'b1,1'b0,1'b1, 0,  0, 1});
    vt.push_back('{1'b0,1'b0,1'b0,1'b1, 5,  0, 1});
    vt.push_back('{1'b0,1'b0,1'b0,1'b0, 5, 15, 1});
    vt.push_back('{1'b0,1'b0,1'b1,1'b1, 5, 15, 1});
    vt.push_back('{1'b0,1'b0,1'b1,1'b0, 5,  0, 1});
    vt.push_back('{1'b1,1'b1,1'b1,1'b0, 7,  0, 1});
    vt.push_back('{1'b0,1'b0,1'b0,1'b0, 7, 15, 1});
    vt.push_back('{1'b0,1'b1,1'b0,1'b0, 0,  0, 0});
    vt.push_back('{1'b0,1'b0,1'b1,1'b0, 3,  1, 1});
    foreach (vt[i]) begin
      rst = vt[i].rst; pe = vt[i].pe; up = vt[i].up; ci_n = vt[i].ci_n;
      p = 4'(vt[i].p);
      #1;
      tick();
      chk($sformatf("vec%0d_q", i), qv(), vt[i].exp_q);
      chk($sformatf("vec%0d_co", i), int'(co_n), vt[i].exp_co);
    end
    rst = 0; pe = 0;

    // Async preset, P change under PE is not seen until a clock, then count on
    pulse_reset();
    p = 4'b1010; pe = 1'b1; #1;
    chk("preset_async", qv(), 10);
    p = 4'b0011; #1;
    chk("preset_p_change_no_edge", qv(), 10);
    tick();
    chk("preset_clock_reload", qv(), 3);
    pe = 1'b0; up = 1'b1; ci_n = 1'b0; #1;
    tick(); chk("preset_count1", qv(), 4);
    tick(); chk("preset_count2", qv(), 5);

    // Carry out follows CI_n and UP/DOWN immediately
    pulse_reset();
    up = 1'b0; ci_n = 1'b0; #1;
    chk("co_down_zero", int'(co_n), 0);
    ci_n = 1'b1; #1;
    chk("co_ci_off", int'(co_n), 1);
    ci_n = 1'b0; up = 1'b1; #1;
    chk("co_up_zero", int'(co_n), 1);

    // Hold with carry in inactive, both directions
    async_load(7);
    ci_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      up = (d == 0);
      for (int k = 0; k < 5; k++) begin
        tick();
        chk($sformatf("hold_d%0d_q", d), qv(), 7);
        chk($sformatf("hold_d%0d_co", d), int'(co_n), 1);
      end
    end

    // Reset mid-count: immediate clear, held through clocks and PE pulses
    async_load(9);
    ci_n = 1'b0; up = 1'b1; #3;
    rst = 1'b1; #1;
    chk("mid_reset_async", qv(), 0);
    p = 4'd12;
    for (int k = 0; k < 3; k++) begin
      pe = 1'b1; #1; pe = 1'b0; #1;
      tick();
      chk("mid_reset_held", qv(), 0);
    end
    rst = 1'b0; #1;
    tick();
    chk("after_reset_count", qv(), 1);

    // Basic count plus two-stage cascade from reset
    pulse_reset();
    up = 1'b1; ci_n = 1'b0; pe = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("casc_lo", qv(), k % 16);
      chk("casc_lo_co", int'(co_n), ((k % 16) == 15) ? 0 : 1);
      chk("casc_hi", hv(), k / 16);
    end
    chk("casc_total", (hv() << 4) | qv(), 'h14);

    // Randomized run against the reference model
    pulse_reset();
    mq = 0; prev_pe = 1'b0; pe = 1'b0;
    for (int k = 0; k < 200; k++) begin
      rst  = ($urandom_range(0, 15) == 0);
      pe   = ($urandom_range(0, 3) == 0);
      up   = 1'($urandom_range(0, 1));
      ci_n = ($urandom_range(0, 3) == 0);
      p    = 4'($urandom_range(0, 15));
      #1;
      if (rst) mq = 0;
      else if (pe && !prev_pe) mq = int'(p);
      chk("rand_pre_q", qv(), mq);
      chk("rand_pre_co", int'(co_n), co_model(mq, up, ci_n));
      tick();
      if (rst) mq = 0;
      else if (pe) mq = int'(p);
      else if (!ci_n) mq = up ? (mq + 1) % 16 : (mq + 15) % 16;
      chk("rand_q", qv(), mq);
      chk("rand_co", int'(co_n), co_model(mq, up, ci_n));
      prev_pe = pe;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
